// File: rtl/seq_div_reconstruct_pkg.sv
// Shared definitions for the divider-result reconstruction unit.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package seq_div_reconstruct_pkg;

   // Default operand width, matching the companion 4-bit divider.
   localparam int DEF_WIDTH = 4;

   // FSM encoding; values are fixed so waveforms match the companion divider docs.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Step counter width: clog2 of the operand width, never narrower than one bit.
   function automatic int cnt_width(input int w);
      int c;
      c = $clog2(w);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/seq_div_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a shift-and-add loop, and flags legal triples.
// Latency: WIDTH+1 edges from acceptance to out_valid (acceptance edge plus WIDTH add/shift steps).
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready is seen.
module seq_div_reconstruct
   import seq_div_reconstruct_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     quotient,
   input  logic [WIDTH-1:0]     divisor,
   input  logic [WIDTH-1:0]     remainder,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   dividend,
   output logic                 consistent,
   output logic                 busy
);

   localparam int              CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e                 state_q, state_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [2*WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]       mplier_q, mplier_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   cons_r_q, cons_r_d;
   logic [2*WIDTH-1:0]     dividend_q, dividend_d;
   logic                   consistent_q, consistent_d;

   logic [2*WIDTH-1:0]     acc_step;
   logic                   legal;

   // A zero divisor is only legal with q=0 (divider returns r=dividend); otherwise r must be below d.
   always_comb begin
      legal = 1'b0;
      if (divisor == '0) begin
         legal = (quotient == '0);
      end else begin
         legal = (remainder < divisor);
      end
   end

   // One add step: accumulate the shifted divisor when the current quotient bit is set.
   // The 2*WIDTH accumulator holds at most 2^(2W)-2^W, so no carry-out is needed.
   always_comb begin
      acc_step = acc_q;
      if (mplier_q[0]) begin
         acc_step = acc_q + mcand_q;
      end
   end

   // Next-state and handshake outputs; every register defaults to holding its value.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      cnt_d        = cnt_q;
      cons_r_d     = cons_r_q;
      dividend_d   = dividend_q;
      consistent_d = consistent_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               acc_d    = {{WIDTH{1'b0}}, remainder};
               mcand_d  = {{WIDTH{1'b0}}, divisor};
               mplier_d = quotient;
               cnt_d    = '0;
               cons_r_d = legal;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // Fixed WIDTH steps, no early exit, so latency never depends on the operands.
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Publish only at the end so outputs never show a partial sum.
               dividend_d   = acc_step;
               consistent_d = cons_r_q;
               state_d      = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         cnt_q        <= '0;
         cons_r_q     <= 1'b0;
         dividend_q   <= '0;
         consistent_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         cnt_q        <= cnt_d;
         cons_r_q     <= cons_r_d;
         dividend_q   <= dividend_d;
         consistent_q <= consistent_d;
      end
   end

   assign dividend   = dividend_q;
   assign consistent = consistent_q;

endmodule

// File: doc/seq_div_reconstruct.md
Name: seq_div_reconstruct

Overview:
- Sequential shift-and-add unit that rebuilds a dividend from quotient, divisor and remainder: dividend = quotient*divisor + remainder.
- Inverse companion of the team's combinational 4-bit divider; used to check or round-trip divider results.
- Also flags whether the input triple is a legal divider output.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
WIDTH, 4, operand width of quotient, divisor and remainder; dividend output is 2*WIDTH bits.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  input triple valid.
in_ready  output  1  block can accept a triple.
quotient  input  WIDTH  unsigned quotient.
divisor  input  WIDTH  unsigned divisor.
remainder  input  WIDTH  unsigned remainder.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
dividend  output  2*WIDTH  reconstructed dividend.
consistent  output  1  triple is a legal divider result.
busy  output  1  high in RUN and DONE states.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, dividend=0, consistent=0, busy=0, internal registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, load acc={WIDTH'b0, remainder}, mcand={WIDTH'b0, divisor}, mplier=quotient, cnt=0.
  - Register consistent_r on that edge; go to RUN.
- consistent_r rules:
  - If divisor==0: consistent_r = (quotient==0). This matches divider semantics q=0, r=dividend.
  - Otherwise: consistent_r = (remainder < divisor).
- RUN, one edge per step:
  - If mplier[0]=1, acc = acc + mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - After WIDTH steps (cnt==WIDTH-1 on the final step), go to DONE.
- No early termination: RUN always takes exactly WIDTH cycles, so latency is fixed.
- Width rule: the accumulator is 2*WIDTH bits and cannot overflow. The maximum is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W. No carry-out port.
- DONE:
  - out_valid=1; dividend=acc; consistent=consistent_r.
  - in_ready=0.
  - Hold all outputs stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and deassert out_valid.
- Latency: acceptance edge E0, then WIDTH RUN edges; out_valid is high from E0+WIDTH+1 (5 edges for WIDTH=4).
- Throughput:
  - Minimum spacing between acceptances is WIDTH+2 edges when out_ready is tied high.
  - No input is accepted in the same cycle a result is consumed; in_ready is only high in IDLE.
- Outputs outside DONE:
  - dividend and consistent hold their last values.
  - out_valid=0 is the only qualifier consumers may rely on.
- Input changes while in RUN or DONE are ignored; operands are captured only at acceptance.
- Reset mid-operation: an asynchronous assert aborts immediately to reset values, no partial result is emitted, and the first post-reset cycle is IDLE.
- busy = (state != IDLE).

Decomposition:
- Shared package/include: state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH=4.
- Counter width is derived by clog2 of WIDTH, with a minimum of 1.
- No sub-module. The datapath is one add-shift stage plus a counter and FSM in a single module.
- The bench instantiates the existing combinational divider as a round-trip golden model.

Test Plan:
1. After reset with WIDTH=4, apply q=3, d=5, r=2 → at edge E0+5: out_valid=1, dividend=17, consistent=1. in_ready=0 throughout RUN and DONE.
2. Apply q=15, d=15, r=15 → dividend=240 (max reachable), consistent=0 (r≥d). Then q=15, d=15, r=14 → dividend=239, consistent=1.
3. Apply q=0, d=0, r=9 → dividend=9, consistent=1. Then q=2, d=0, r=9 → dividend=9, consistent=0.
4. Hold out_ready=0 for 6 cycles in DONE → dividend, consistent and out_valid remain stable, in_ready stays 0. Raising out_ready returns the block to IDLE on the next edge.
5. Assert rst during the 2nd RUN cycle → out_valid=0, in_ready=1, dividend=0 immediately. A new triple q=1, d=1, r=0 then yields dividend=1.
6. Exhaustive round trip for all 256 dividend/divisor pairs: run through the divider, feed its q and r back with out_ready=1 and in_valid held high → dividend matches the original, consistent=1, and accepted triples are spaced exactly 6 edges apart.
